// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing with
// PREADY wait states, and a wait-timeout abort so a silent slave cannot hang the bus.
module apb_master_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e              r_state, w_state_nxt;
    logic                r_last_grant, w_last_grant_nxt;
    logic                r_gnt, w_gnt_nxt;
    logic                r_write, w_write_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [CntW-1:0]     r_cnt, w_cnt_nxt;
    logic [1:0]          r_rsp_valid, w_rsp_valid_nxt;
    logic                r_rsp_err, w_rsp_err_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic                w_pick;

    // Under contention the requester that did not win last time goes next.
    always_comb begin
        if (&req_valid) begin
            w_pick = ~r_last_grant;
        end else begin
            w_pick = req_valid[1];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_rsp_valid  <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_gnt        <= w_gnt_nxt;
            r_write      <= w_write_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
            r_rsp_rdata  <= w_rsp_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_gnt_nxt        = r_gnt;
        w_write_nxt      = r_write;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_cnt_nxt        = r_cnt;
        w_rsp_valid_nxt  = '0;
        w_rsp_err_nxt    = 1'b0;
        w_rsp_rdata_nxt  = '0;
        req_ready        = '0;

        case (r_state)
            StIdle: begin
                if (|req_valid) begin
                    // Gated so an accept can never be seen while reset is held.
                    req_ready        = PRESETn ? (w_pick ? 2'b10 : 2'b01) : 2'b00;
                    w_gnt_nxt        = w_pick;
                    w_last_grant_nxt = w_pick;
                    w_write_nxt      = w_pick ? req_write[1] : req_write[0];
                    w_addr_nxt       = w_pick ? req_addr[2*ADDR_W-1:ADDR_W]
                                              : req_addr[ADDR_W-1:0];
                    w_wdata_nxt      = w_pick ? req_wdata[2*DATA_W-1:DATA_W]
                                              : req_wdata[DATA_W-1:0];
                    w_state_nxt      = StSetup;
                end
            end
            StSetup: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    w_rsp_valid_nxt = r_gnt ? 2'b10 : 2'b01;
                    w_rsp_rdata_nxt = r_write ? '0 : PRDATA;
                    w_state_nxt     = StIdle;
                end else if (r_cnt == CntW'(MAX_WAIT)) begin
                    w_rsp_valid_nxt = r_gnt ? 2'b10 : 2'b01;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign PSEL      = (r_state != StIdle);
    assign PENABLE   = (r_state == StAccess);
    assign PWRITE    = r_write;
    assign PADDR     = r_addr;
    assign PWDATA    = r_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed reset-in-ACCESS check, then randomized traffic
// scored against a transaction-level timeline model of arbitration, latency and memory.
module tb_apb_master_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MW = 15;
    localparam int N  = 24;
    localparam int NT = 2 * N;

    logic           PCLK = 1'b0;
    logic           PRESETn;
    logic [1:0]     req_valid, req_ready, req_write;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]     rsp_valid;
    logic           rsp_err;
    logic [DW-1:0]  rsp_rdata;
    logic           PSEL, PENABLE, PWRITE;
    logic [AW-1:0]  PADDR;
    logic [DW-1:0]  PWDATA, PRDATA;
    logic           PREADY;

    apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {int c; int g;} gnt_t;
    typedef struct {int c; int g; logic e; logic [31:0] d;} rsp_t;
    typedef struct {logic [7:0] a; logic w; logic [31:0] d;} bus_t;

    gnt_t gq[$];
    rsp_t rq[$];
    bus_t bq[$];

    int          gap[2][N];
    logic        wr[2][N];
    logic [7:0]  ad[2][N];
    logic [31:0] wd[2][N];
    int          wl[NT];
    logic [31:0] smem[256];
    logic [31:0] mmem[256];
    bit          rnd_on = 1'b0;

    // Scoreboard monitor: pops expectations by cycle and compares what the DUT presents.
    always @(negedge PCLK) begin
        if (rnd_on) begin
            logic [1:0] exp_rdy;
            rsp_t r;
            bus_t b;
            exp_rdy = 2'b00;
            if (gq.size() > 0 && gq[0].c == cyc) begin
                exp_rdy = (gq[0].g == 1) ? 2'b10 : 2'b01;
                void'(gq.pop_front());
            end
            if (exp_rdy != 2'b00 || req_ready != 2'b00) chk("grant", req_ready, exp_rdy);
            if (rq.size() > 0 && rq[0].c == cyc) begin
                r = rq.pop_front();
                chk("rsp_valid", rsp_valid, (r.g == 1) ? 2'b10 : 2'b01);
                chk("rsp_err", rsp_err, r.e);
                chk("rsp_rdata", rsp_rdata, r.d);
            end else if (rsp_valid != 2'b00) begin
                chk("rsp_unexpected", rsp_valid, 2'b00);
            end
            if (PSEL && !PENABLE) begin
                if (bq.size() > 0) begin
                    b = bq.pop_front();
                    chk("paddr", PADDR, b.a);
                    chk("pwrite", PWRITE, b.w);
                    chk("pwdata", PWDATA, b.d);
                end else begin
                    chk("bus_extra", {PSEL, PENABLE}, 2'b00);
                end
            end
        end
    end

    int   p[2], vf[2], dp[2], dvf[2];
    int   t, lastg, g, n, w, done, c0, end_cyc, sidx, cur, acc, k;
    bit   c0b, c1b;
    gnt_t ge;
    rsp_t re;
    bus_t be;

    initial begin
        PRESETn   = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        #1 PRESETn = 1'b0;

        // Reset values and a transfer cut off by reset in ACCESS.
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset_ctl", {req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE, PADDR}, '0);
        chk("reset_data", {rsp_rdata, PWDATA}, '0);
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr[7:0]   = 8'h10;
        req_wdata[31:0] = 32'hDEADBEEF;
        @(negedge PCLK);
        chk("dir_accept", req_ready, 2'b01);
        @(posedge PCLK);
        #1 req_valid = 2'b00;
        @(negedge PCLK);
        chk("dir_setup", {PSEL, PENABLE}, 2'b10);
        chk("dir_paddr", PADDR, 8'h10);
        chk("dir_pwdata", PWDATA, 32'hDEADBEEF);
        chk("dir_pwrite", PWRITE, 1'b1);
        @(negedge PCLK);
        chk("dir_access", {PSEL, PENABLE}, 2'b11);
        @(posedge PCLK);
        #1;
        PRESETn   = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("midreset_ctl", {req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE, PADDR}, '0);
        chk("midreset_data", {rsp_rdata, PWDATA}, '0);
        repeat (2) @(posedge PCLK);
        #1;
        req_valid = 2'b00;
        PRESETn   = 1'b1;
        repeat (6) begin
            @(negedge PCLK);
            chk("no_spurious", {rsp_valid, PSEL}, 3'b000);
        end

        // Random traffic; first few entries pinned to the key boundary cases.
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < N; j++) begin
                gap[i][j] = ($urandom % 4 == 0) ? int'($urandom_range(1, 8)) : 0;
                wr[i][j]  = 1'($urandom % 2);
                ad[i][j]  = 8'h10 + 8'($urandom % 8);
                wd[i][j]  = $urandom;
            end
        end
        for (int j = 0; j < NT; j++) begin
            k = int'($urandom % 20);
            if (k < 10)       wl[j] = 0;
            else if (k < 15)  wl[j] = int'($urandom_range(1, 4));
            else if (k < 17)  wl[j] = MW;
            else if (k < 19)  wl[j] = MW + 1;
            else              wl[j] = int'($urandom_range(5, 14));
        end
        gap[0][0] = 0; wr[0][0] = 1'b1; ad[0][0] = 8'h10; wd[0][0] = 32'hDEADBEEF;
        gap[1][0] = 0; wr[1][0] = 1'b0; ad[1][0] = 8'h10;
        wl[0] = 0; wl[1] = 3; wl[2] = MW + 1; wl[3] = MW;
        for (int a = 0; a < 256; a++) begin
            smem[a] = 32'hA5A50000 | 32'(a);
            mmem[a] = 32'hA5A50000 | 32'(a);
        end

        // Timeline model: DUT is idle at t; accept at t, response at t+3+waits
        // (or t+MW+3 on timeout), and that response cycle is the next accept chance.
        c0 = cyc + 1;
        p[0] = 0; p[1] = 0;
        vf[0] = c0 + gap[0][0];
        vf[1] = c0 + gap[1][0];
        t = c0; lastg = 1; n = 0;
        while (p[0] < N || p[1] < N) begin
            c0b = (p[0] < N) && (vf[0] <= t);
            c1b = (p[1] < N) && (vf[1] <= t);
            if (!c0b && !c1b) begin
                t = (p[0] < N) ? vf[0] : vf[1];
                if (p[1] < N && vf[1] < t) t = vf[1];
                continue;
            end
            if (c0b && c1b) g = 1 - lastg;
            else            g = c1b ? 1 : 0;
            lastg = g;
            ge.c = t; ge.g = g;
            gq.push_back(ge);
            be.a = ad[g][p[g]]; be.w = wr[g][p[g]]; be.d = wd[g][p[g]];
            bq.push_back(be);
            w = wl[n];
            n++;
            re.g = g;
            if (w <= MW) begin
                done = t + 3 + w;
                re.e = 1'b0;
                if (wr[g][p[g]]) begin
                    re.d = '0;
                    mmem[ad[g][p[g]]] = wd[g][p[g]];
                end else begin
                    re.d = mmem[ad[g][p[g]]];
                end
            end else begin
                done = t + MW + 3;
                re.e = 1'b1;
                re.d = '0;
            end
            re.c = done;
            rq.push_back(re);
            p[g]++;
            if (p[g] < N) vf[g] = t + 1 + gap[g][p[g]];
            t = done;
        end
        end_cyc = t + 6;
        rnd_on  = 1'b1;

        dp[0] = 0; dp[1] = 0;
        dvf[0] = c0 + gap[0][0];
        dvf[1] = c0 + gap[1][0];
        sidx = 0; cur = 0; acc = 0;
        while (cyc < end_cyc && cyc < c0 + 50000) begin
            @(posedge PCLK);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (dp[i] < N && cyc >= dvf[i]) begin
                    req_valid[i] = 1'b1;
                    req_write[i] = wr[i][dp[i]];
                    req_addr[i*AW +: AW]  = ad[i][dp[i]];
                    req_wdata[i*DW +: DW] = wd[i][dp[i]];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            // Slave: the n-th transfer on the bus holds PREADY low for wl[n] ACCESS cycles.
            if (PSEL && !PENABLE) begin
                cur = sidx;
                sidx++;
                acc = 0;
                PREADY = 1'($urandom % 2);
                PRDATA = $urandom;
            end else if (PSEL && PENABLE) begin
                PREADY = (cur < NT) ? (acc == wl[cur]) : 1'b1;
                PRDATA = (PREADY && !PWRITE) ? smem[PADDR] : $urandom;
                if (PREADY && PWRITE) smem[PADDR] = PWDATA;
                acc++;
            end else begin
                PREADY = 1'($urandom % 2);
                PRDATA = $urandom;
            end
            @(negedge PCLK);
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    dp[i]++;
                    if (dp[i] < N) dvf[i] = cyc + 1 + gap[i][dp[i]];
                end
            end
        end

        chk("grants_left", gq.size(), 0);
        chk("rsps_left", rq.size(), 0);
        chk("bus_left", bq.size(), 0);
        chk("req0_consumed", dp[0], N);
        chk("req1_consumed", dp[1], N);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
